// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : RV32I opcode and pipeline-control types  | Rev 1.0
// ============================================================================
`default_nettype none

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
endpackage

package pipe_ctrl_types;
  typedef enum logic [0:0] {S_RUN = 1'b0, S_KILL = 1'b1} hz_state_t;
  typedef enum logic [0:0] {pc_plus4 = 1'b0, redirect = 1'b1} pcmux_t;
endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if : hazard controller pipeline status / control bundle | Rev 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(parameter int CNT_WIDTH = 32);
  import rv32i_types::*;
  import pipe_ctrl_types::*;

  logic                 imem_read;
  logic                 imem_resp;
  logic                 dmem_req;
  logic                 dmem_resp;
  logic [4:0]           fd_rs1;
  logic [4:0]           fd_rs2;
  logic                 fd_uses_rs1;
  logic                 fd_uses_rs2;
  logic                 fd_valid_out;
  rv32i_opcode          de_opcode;
  logic [4:0]           de_rd;
  logic                 de_valid_out;
  logic                 br_taken;
  logic [31:0]          br_target;
  logic                 load_pc;
  logic                 load_fd;
  logic                 load_de;
  logic                 load_em;
  logic                 load_mw;
  logic                 fd_bubble;
  logic                 de_bubble;
  pcmux_t               pcmux_sel;
  logic [31:0]          redirect_pc;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp,
           fd_rs1, fd_rs2, fd_uses_rs1, fd_uses_rs2, fd_valid_out,
           de_opcode, de_rd, de_valid_out, br_taken, br_target,
    input  load_pc, load_fd, load_de, load_em, load_mw,
           fd_bubble, de_bubble, pcmux_sel, redirect_pc,
           stall_count, flush_count
  );

  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp,
           fd_rs1, fd_rs2, fd_uses_rs1, fd_uses_rs2, fd_valid_out,
           de_opcode, de_rd, de_valid_out, br_taken, br_target,
    output load_pc, load_fd, load_de, load_em, load_mw,
           fd_bubble, de_bubble, pcmux_sel, redirect_pc,
           stall_count, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_load_use_detector.sv
// ============================================================================
// load_use_detector : flags an ID read of a register a load in EX will write
// Rev 1.0
// ============================================================================
`default_nettype none

module load_use_detector
  import rv32i_types::*;
(
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rs2,
  input  logic        fd_uses_rs1,
  input  logic        fd_uses_rs2,
  input  logic        fd_valid_out,
  input  rv32i_opcode de_opcode,
  input  logic [4:0]  de_rd,
  input  logic        de_valid_out,
  output logic        lu
);
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = fd_uses_rs1 && (fd_rs1 == de_rd);
    rs2_hit = fd_uses_rs2 && (fd_rs2 == de_rd);
    // x0 is never written, so a load targeting it cannot create a hazard
    lu = de_valid_out && fd_valid_out && (de_opcode == op_load) &&
         (de_rd != 5'd0) && (rs1_hit || rs2_hit);
  end
endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : 5-stage pipeline stall/flush sequencing with perf counters
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import rv32i_types::*;
  import pipe_ctrl_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_KILL = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic dstall, istall, flush, lu, flush_accept;
  logic load_pc, load_fd, load_de, load_em, load_mw;
  logic fd_bubble, de_bubble;
  pcmux_t pcmux_sel;
  logic [31:0] redirect_pc;

  load_use_detector u_lud (
    .fd_rs1       (hz.fd_rs1),
    .fd_rs2       (hz.fd_rs2),
    .fd_uses_rs1  (hz.fd_uses_rs1),
    .fd_uses_rs2  (hz.fd_uses_rs2),
    .fd_valid_out (hz.fd_valid_out),
    .de_opcode    (hz.de_opcode),
    .de_rd        (hz.de_rd),
    .de_valid_out (hz.de_valid_out),
    .lu           (lu)
  );

  always_comb begin
    dstall = hz.dmem_req && !hz.dmem_resp;
    istall = hz.imem_read && !hz.imem_resp;
    flush  = hz.br_taken && hz.de_valid_out;

    load_pc       = 1'b1;
    load_fd       = 1'b1;
    load_de       = 1'b1;
    load_em       = 1'b1;
    load_mw       = 1'b1;
    fd_bubble     = 1'b0;
    de_bubble     = 1'b0;
    pcmux_sel     = pc_plus4;
    redirect_pc   = redirect_pc_q;
    redirect_pc_d = redirect_pc_q;
    state_d       = state_q;
    flush_accept  = 1'b0;

    if (rst) begin
      fd_bubble = 1'b1;
      de_bubble = 1'b1;
      state_d   = ST_RUN;
    end else if (dstall) begin
      load_pc = 1'b0;
      load_fd = 1'b0;
      load_de = 1'b0;
      load_em = 1'b0;
      load_mw = 1'b0;
    end else if (state_q == ST_KILL) begin
      de_bubble = 1'b1;
      if (!hz.imem_resp) begin
        load_pc = 1'b0;
        load_fd = 1'b0;
      end else begin
        // the word answering the killed fetch is dropped as it lands
        fd_bubble = 1'b1;
        pcmux_sel = redirect;
        state_d   = ST_RUN;
      end
    end else if (flush && istall) begin
      // fetch address must stay stable until the outstanding request returns
      load_pc       = 1'b0;
      fd_bubble     = 1'b1;
      de_bubble     = 1'b1;
      redirect_pc_d = hz.br_target;
      state_d       = ST_KILL;
      flush_accept  = 1'b1;
    end else if (flush) begin
      fd_bubble    = 1'b1;
      de_bubble    = 1'b1;
      pcmux_sel    = redirect;
      redirect_pc  = hz.br_target;
      flush_accept = 1'b1;
    end else if (istall || lu) begin
      load_pc   = 1'b0;
      load_fd   = 1'b0;
      de_bubble = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (!rst && !load_pc) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
    flush_count_d = flush_count_q;
    if (!rst && flush_accept) begin
      flush_count_d = flush_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      redirect_pc_q <= 32'h0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.load_pc     = load_pc;
  assign hz.load_fd     = load_fd;
  assign hz.load_de     = load_de;
  assign hz.load_em     = load_em;
  assign hz.load_mw     = load_mw;
  assign hz.fd_bubble   = fd_bubble;
  assign hz.de_bubble   = de_bubble;
  assign hz.pcmux_sel   = pcmux_sel;
  assign hz.redirect_pc = redirect_pc;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : vector table, directed sequences and random vs. model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import rv32i_types::*;
  import pipe_ctrl_types::*;

  typedef struct {
    logic        rst, imem_read, imem_resp, dmem_req, dmem_resp;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, fdv;
    rv32i_opcode op;
    logic [4:0]  rd;
    logic        dev, br;
    logic [31:0] tgt;
  } in_t;

  typedef struct packed {
    logic        load_pc, load_fd, load_de, load_em, load_mw;
    logic        fd_bubble, de_bubble, pcsel;
    logic [31:0] rpc;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_WIDTH(32)) hz ();
  hazard_ctrl #(.CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .hz(hz));

  int checks = 0;
  int errors = 0;

  // reference state: is a killed fetch pending, where to go after, counters
  bit          m_kill = 1'b0;
  logic [31:0] m_tgt  = 32'h0;
  logic [31:0] m_stall = 32'h0;
  logic [31:0] m_flush = 32'h0;

  function automatic in_t idle();
    in_t v;
    v.rst = 1'b0; v.imem_read = 1'b1; v.imem_resp = 1'b1;
    v.dmem_req = 1'b0; v.dmem_resp = 1'b0;
    v.rs1 = 5'd0; v.rs2 = 5'd0; v.u1 = 1'b0; v.u2 = 1'b0; v.fdv = 1'b0;
    v.op = op_reg; v.rd = 5'd0; v.dev = 1'b0; v.br = 1'b0; v.tgt = 32'h0;
    return v;
  endfunction

  function automatic out_t model(input in_t v);
    out_t o;
    bit freeze, fetch_busy, take, hazard;
    freeze     = v.dmem_req && !v.dmem_resp;
    fetch_busy = v.imem_read && !v.imem_resp;
    take       = v.br && v.dev;
    hazard     = v.dev && v.fdv && v.op == op_load && v.rd != 5'd0 &&
                 ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    o = '{load_pc: 1'b1, load_fd: 1'b1, load_de: 1'b1, load_em: 1'b1,
          load_mw: 1'b1, fd_bubble: 1'b0, de_bubble: 1'b0, pcsel: 1'b0,
          rpc: 32'h0};
    if (v.rst) begin
      o.fd_bubble = 1'b1;
      o.de_bubble = 1'b1;
    end else if (freeze) begin
      o.load_pc = 1'b0; o.load_fd = 1'b0; o.load_de = 1'b0;
      o.load_em = 1'b0; o.load_mw = 1'b0;
    end else if (m_kill) begin
      o.de_bubble = 1'b1;
      if (!v.imem_resp) begin
        o.load_pc = 1'b0; o.load_fd = 1'b0;
      end else begin
        o.fd_bubble = 1'b1; o.pcsel = 1'b1; o.rpc = m_tgt;
      end
    end else if (take) begin
      o.fd_bubble = 1'b1; o.de_bubble = 1'b1;
      if (fetch_busy) o.load_pc = 1'b0;
      else begin o.pcsel = 1'b1; o.rpc = v.tgt; end
    end else if (fetch_busy || hazard) begin
      o.load_pc = 1'b0; o.load_fd = 1'b0; o.de_bubble = 1'b1;
    end
    return o;
  endfunction

  task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input in_t v, input out_t exp, input string name);
    out_t got, e;
    @(negedge clk);
    rst = v.rst;
    hz.imem_read = v.imem_read; hz.imem_resp = v.imem_resp;
    hz.dmem_req = v.dmem_req;   hz.dmem_resp = v.dmem_resp;
    hz.fd_rs1 = v.rs1; hz.fd_rs2 = v.rs2;
    hz.fd_uses_rs1 = v.u1; hz.fd_uses_rs2 = v.u2; hz.fd_valid_out = v.fdv;
    hz.de_opcode = v.op; hz.de_rd = v.rd; hz.de_valid_out = v.dev;
    hz.br_taken = v.br; hz.br_target = v.tgt;
    #1;
    if (m_kill && !v.rst)
      assert (!(v.br && v.dev)) else $error("br_taken while a fetch is being killed");
    got = '{hz.load_pc, hz.load_fd, hz.load_de, hz.load_em, hz.load_mw,
            hz.fd_bubble, hz.de_bubble, (hz.pcmux_sel == redirect), hz.redirect_pc};
    e = exp;
    if (!e.pcsel) begin got.rpc = 32'h0; e.rpc = 32'h0; end
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got ld{pc,fd,de,em,mw}=%b%b%b%b%b bub{fd,de}=%b%b redir=%b pc=%h expected %b%b%b%b%b %b%b %b %h",
               name, got.load_pc, got.load_fd, got.load_de, got.load_em, got.load_mw,
               got.fd_bubble, got.de_bubble, got.pcsel, got.rpc,
               e.load_pc, e.load_fd, e.load_de, e.load_em, e.load_mw,
               e.fd_bubble, e.de_bubble, e.pcsel, e.rpc);
    end
    cmp32({name, " stall_count"}, hz.stall_count, m_stall);
    cmp32({name, " flush_count"}, hz.flush_count, m_flush);
    // advance the reference across the coming rising edge
    if (v.rst) begin
      m_kill = 1'b0; m_tgt = 32'h0; m_stall = 32'h0; m_flush = 32'h0;
    end else begin
      if (!exp.load_pc) m_stall = m_stall + 32'd1;
      if (!(v.dmem_req && !v.dmem_resp)) begin
        if (m_kill) begin
          if (v.imem_resp) m_kill = 1'b0;
        end else if (v.br && v.dev) begin
          m_flush = m_flush + 32'd1;
          if (v.imem_read && !v.imem_resp) begin m_kill = 1'b1; m_tgt = v.tgt; end
        end
      end
    end
  endtask

  task automatic run(input in_t v, input string name);
    apply(v, model(v), name);
  endtask

  vec_t tbl[13];
  localparam out_t ALL  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
  localparam out_t STL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
  localparam out_t FRZ  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
  localparam out_t BR60 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h60};

  initial begin
    in_t v, lu_v;
    lu_v = idle();
    lu_v.fdv = 1'b1; lu_v.dev = 1'b1; lu_v.op = op_load;
    lu_v.rd = 5'd5; lu_v.rs1 = 5'd5; lu_v.u1 = 1'b1; lu_v.rs2 = 5'd7;

    tbl[0] = '{idle(), ALL};
    tbl[1] = '{lu_v, STL};
    v = lu_v; v.rd = 5'd0; v.rs1 = 5'd0;     tbl[2] = '{v, ALL};
    v = lu_v; v.u1 = 1'b0;                    tbl[3] = '{v, ALL};
    v = lu_v; v.u1 = 1'b0; v.u2 = 1'b1; v.rs2 = 5'd5; tbl[4] = '{v, STL};
    v = lu_v; v.op = op_reg;                  tbl[5] = '{v, ALL};
    v = idle(); v.dev = 1'b1; v.br = 1'b1; v.tgt = 32'h60; tbl[6] = '{v, BR60};
    v = idle(); v.br = 1'b1; v.tgt = 32'h60;  tbl[7] = '{v, ALL};
    v = idle(); v.imem_resp = 1'b0;           tbl[8] = '{v, STL};
    v = lu_v; v.dmem_req = 1'b1;              tbl[9] = '{v, FRZ};
    v = lu_v; v.dmem_req = 1'b1; v.dmem_resp = 1'b1; tbl[10] = '{v, STL};
    v = idle(); v.imem_read = 1'b0; v.imem_resp = 1'b0; tbl[11] = '{v, ALL};
    v = lu_v; v.br = 1'b1; v.tgt = 32'h60;    tbl[12] = '{v, BR60};

    hz.imem_read = 1'b0; hz.imem_resp = 1'b0; hz.dmem_req = 1'b0; hz.dmem_resp = 1'b0;
    hz.fd_rs1 = 5'd0; hz.fd_rs2 = 5'd0; hz.fd_uses_rs1 = 1'b0; hz.fd_uses_rs2 = 1'b0;
    hz.fd_valid_out = 1'b0; hz.de_opcode = op_reg; hz.de_rd = 5'd0;
    hz.de_valid_out = 1'b0; hz.br_taken = 1'b0; hz.br_target = 32'h0;
    repeat (2) @(posedge clk);

    v = idle(); v.rst = 1'b1;
    apply(v, '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0}, "reset");

    for (int k = 0; k < 13; k++) apply(tbl[k].i, tbl[k].o, $sformatf("vec[%0d]", k));

    // flush during an outstanding fetch, response 3 cycles later
    v = idle(); v.imem_resp = 1'b0; v.dev = 1'b1; v.br = 1'b1; v.tgt = 32'h80;
    run(v, "kill_enter");
    v = idle(); v.imem_resp = 1'b0;
    for (int k = 0; k < 3; k++) run(v, "kill_wait");
    v = idle(); run(v, "kill_resp");
    run(v, "kill_after");

    // memory wait dominates a concurrent load-use and fetch stall
    v = lu_v; v.imem_resp = 1'b0; v.dmem_req = 1'b1;
    for (int k = 0; k < 5; k++) run(v, "dstall_hold");
    v.dmem_resp = 1'b1; run(v, "dstall_release");

    // reset while a kill is pending drops the redirect
    v = idle(); v.imem_resp = 1'b0; v.dev = 1'b1; v.br = 1'b1; v.tgt = 32'h80;
    run(v, "rkill_enter");
    v = idle(); v.imem_resp = 1'b0; run(v, "rkill_wait");
    v = idle(); v.rst = 1'b1; run(v, "rkill_reset");
    v = idle(); run(v, "rkill_after");

    // stall counter wraps
    @(posedge clk); #1;
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1 release dut.stall_count_q;
    m_stall = 32'hFFFF_FFFF;
    v = idle(); v.imem_resp = 1'b0; run(v, "wrap_stall");
    v = idle(); run(v, "wrap_after");

    for (int n = 0; n < 3000; n++) begin
      v.rst       = ($urandom_range(0, 63) == 0);
      v.imem_read = ($urandom_range(0, 3) != 0);
      v.imem_resp = $urandom_range(0, 1);
      v.dmem_req  = ($urandom_range(0, 2) == 0);
      v.dmem_resp = $urandom_range(0, 1);
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.u1 = $urandom_range(0, 1); v.u2 = $urandom_range(0, 1);
      v.fdv = $urandom_range(0, 1);
      v.op  = ($urandom_range(0, 1) == 1) ? op_load : op_store;
      v.rd  = 5'($urandom_range(0, 3));
      v.dev = $urandom_range(0, 1);
      v.br  = ($urandom_range(0, 3) == 0);
      v.tgt = $urandom & 32'hFFFF_FFFC;
      if (m_kill) begin v.dev = 1'b0; v.br = 1'b0; end
      run(v, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
